// File: rtl/ysyx_25020037_gpr_sb_pkg.sv
// Shared configuration for the GPR scoreboard: in-flight limits and FSM states.
package ysyx_25020037_gpr_sb_pkg;

  localparam int unsigned SB_MAX_OUT = 4;
  localparam int unsigned SB_CNT_W   = 3;
  localparam int unsigned GPR_N      = 32;
  localparam int unsigned GPR_AW     = 5;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sb_state_e;

endpackage

// File: rtl/ysyx_25020037_gpr_sb_cnt.sv
// In-flight instruction counter: clear has priority, inc+dec cancel, dec saturates at 0.
module ysyx_25020037_sb_cnt
  import ysyx_25020037_gpr_sb_pkg::*;
#(
  parameter int unsigned CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count update; a decrement at zero holds the counter at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ysyx_25020037_gpr_sb.sv
// GPR scoreboard: tracks pending writes per register, limits in-flight
// instructions, and drains the pipeline on a fence request.
module ysyx_25020037_gpr_sb
  import ysyx_25020037_gpr_sb_pkg::*;
#(
  parameter int unsigned MAX_OUT = SB_MAX_OUT,
  parameter int unsigned CNT_W   = SB_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    idu_valid,
  output logic                    sb_ready,
  input  logic [GPR_AW-1:0]       idu_rs1,
  input  logic [GPR_AW-1:0]       idu_rs2,
  input  logic [GPR_AW-1:0]       idu_rd,
  input  logic                    idu_rs1_en,
  input  logic                    idu_rs2_en,
  input  logic                    idu_rd_wen,
  input  logic                    wbu_valid,
  input  logic [GPR_AW-1:0]       wbu_rd,
  input  logic                    wbu_wen,
  input  logic                    fence_req,
  output logic                    fence_done,
  input  logic                    flush,
  output logic [GPR_N-1:0]        busy_vec,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    sb_err
);

  logic [GPR_N-1:0] r_busy;
  logic [GPR_N-1:0] w_busy_nxt;
  sb_state_e        r_state;
  logic             r_fence_done;
  logic             r_err;
  logic [CNT_W-1:0] w_cnt;
  logic             w_hazard;
  logic             w_room;
  logic             w_ready;
  logic             w_fire;
  logic             w_rel_err;

  // Hazard uses registered busy bits only, so a release is seen one cycle later.
  always_comb begin
    w_hazard = (idu_rs1_en & r_busy[idu_rs1])
             | (idu_rs2_en & r_busy[idu_rs2])
             | (idu_rd_wen & r_busy[idu_rd]);
    w_room   = (w_cnt < CNT_W'(MAX_OUT));
    w_ready  = (r_state == ST_RUN) & ~w_hazard & w_room & ~flush;
    w_fire   = idu_valid & w_ready;
  end

  assign sb_ready = w_ready;

  // Next busy vector: clear on release, then set on issue so a same-cycle set wins; x0 never tracked.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wbu_valid && wbu_wen) begin
      w_busy_nxt[wbu_rd] = 1'b0;
    end
    if (w_fire && idu_rd_wen) begin
      w_busy_nxt[idu_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Busy vector register; flush wipes all pending writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= '0;
    end else if (flush) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  ysyx_25020037_sb_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_fire),
    .i_dec (wbu_valid),
    .i_clr (flush),
    .o_cnt (w_cnt)
  );

  // RUN/DRAIN sequencing with a registered one-cycle fence_done on drain completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_fence_done <= 1'b0;
    end else if (flush) begin
      r_state      <= ST_RUN;
      r_fence_done <= 1'b0;
    end else begin
      r_fence_done <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (fence_req) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_cnt == '0) begin
            r_state      <= ST_RUN;
            r_fence_done <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Retire with nothing in flight, or release of a register that is not pending.
  assign w_rel_err = wbu_valid &
                     ((w_cnt == '0) |
                      (wbu_wen & (wbu_rd != '0) & ~r_busy[wbu_rd]));

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_rel_err) begin
      r_err <= 1'b1;
    end
  end

  assign busy_vec    = r_busy;
  assign outstanding = w_cnt;
  assign fence_done  = r_fence_done;
  assign sb_err      = r_err;

endmodule

// File: tb/tb_ysyx_25020037_gpr_sb.sv
// Directed self-checking bench for the GPR scoreboard.
module tb_ysyx_25020037_gpr_sb;

  logic        clk;
  logic        rst;
  logic        idu_valid;
  logic        sb_ready;
  logic [4:0]  idu_rs1;
  logic [4:0]  idu_rs2;
  logic [4:0]  idu_rd;
  logic        idu_rs1_en;
  logic        idu_rs2_en;
  logic        idu_rd_wen;
  logic        wbu_valid;
  logic [4:0]  wbu_rd;
  logic        wbu_wen;
  logic        fence_req;
  logic        fence_done;
  logic        flush;
  logic [31:0] busy_vec;
  logic [2:0]  outstanding;
  logic        sb_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ysyx_25020037_gpr_sb #(
    .MAX_OUT (4),
    .CNT_W   (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .idu_valid   (idu_valid),
    .sb_ready    (sb_ready),
    .idu_rs1     (idu_rs1),
    .idu_rs2     (idu_rs2),
    .idu_rd      (idu_rd),
    .idu_rs1_en  (idu_rs1_en),
    .idu_rs2_en  (idu_rs2_en),
    .idu_rd_wen  (idu_rd_wen),
    .wbu_valid   (wbu_valid),
    .wbu_rd      (wbu_rd),
    .wbu_wen     (wbu_wen),
    .fence_req   (fence_req),
    .fence_done  (fence_done),
    .flush       (flush),
    .busy_vec    (busy_vec),
    .outstanding (outstanding),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [4:0] rd, input logic wen,
                         input logic [4:0] rs1, input logic rs1en,
                         input logic [4:0] rs2, input logic rs2en);
    idu_valid  = v;
    idu_rd     = rd;
    idu_rd_wen = wen;
    idu_rs1    = rs1;
    idu_rs1_en = rs1en;
    idu_rs2    = rs2;
    idu_rs2_en = rs2en;
  endtask

  task automatic retire(input logic v, input logic [4:0] rd, input logic wen);
    wbu_valid = v;
    wbu_rd    = rd;
    wbu_wen   = wen;
  endtask

  task automatic idle();
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    retire(1'b0, 5'd0, 1'b0);
    fence_req = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #3;
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_out", {29'd0, outstanding}, 32'd0);
    chk("rst_fdone", {31'd0, fence_done}, 32'd0);
    chk("rst_err", {31'd0, sb_err}, 32'd0);
    chk("rst_ready", {31'd0, sb_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b1;

    // RAW on rd=5: stall until one cycle after release
    present(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("raw_ready_first", {31'd0, sb_ready}, 32'd1);
    tick();
    chk("raw_busy5", busy_vec, 32'h0000_0020);
    chk("raw_out1", {29'd0, outstanding}, 32'd1);
    present(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0);
    #1 chk("raw_stall", {31'd0, sb_ready}, 32'd0);
    tick();
    chk("raw_no_fire", busy_vec, 32'h0000_0020);
    retire(1'b1, 5'd5, 1'b1);
    #1 chk("raw_no_bypass", {31'd0, sb_ready}, 32'd0);
    tick();
    chk("raw_released", busy_vec, 32'h0);
    chk("raw_out0", {29'd0, outstanding}, 32'd0);
    retire(1'b0, 5'd0, 1'b0);
    #1 chk("raw_ready_after", {31'd0, sb_ready}, 32'd1);
    tick();
    chk("raw_issued6", busy_vec, 32'h0000_0040);
    chk("raw_out_again", {29'd0, outstanding}, 32'd1);
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    retire(1'b1, 5'd6, 1'b1);
    tick();
    retire(1'b0, 5'd0, 1'b0);
    chk("raw_clean_busy", busy_vec, 32'h0);
    chk("raw_clean_out", {29'd0, outstanding}, 32'd0);

    // Fill to MAX_OUT, then one non-writing retire, then flush
    for (int i = 1; i <= 4; i++) begin
      present(1'b1, 5'(i), 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      #1 chk("fill_ready", {31'd0, sb_ready}, 32'd1);
      tick();
    end
    chk("fill_out4", {29'd0, outstanding}, 32'd4);
    chk("fill_busy", busy_vec, 32'h0000_001E);
    present(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd0, 1'b0);
    #1 chk("full_stall", {31'd0, sb_ready}, 32'd0);
    tick();
    chk("full_hold", {29'd0, outstanding}, 32'd4);
    retire(1'b1, 5'd0, 1'b0);
    #1 chk("full_same_cycle", {31'd0, sb_ready}, 32'd0);
    tick();
    retire(1'b0, 5'd0, 1'b0);
    chk("retire_out3", {29'd0, outstanding}, 32'd3);
    chk("retire_busy", busy_vec, 32'h0000_001E);
    #1 chk("retire_ready", {31'd0, sb_ready}, 32'd1);
    flush = 1'b1;
    #1 chk("flush_blocks", {31'd0, sb_ready}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_busy", busy_vec, 32'h0);
    chk("flush_out", {29'd0, outstanding}, 32'd0);
    chk("flush_err", {31'd0, sb_err}, 32'd0);
    idle();

    // Same-cycle issue and retire; forced set/clear collision on rd=7
    present(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    present(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("pair_out2", {29'd0, outstanding}, 32'd2);
    present(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    retire(1'b1, 5'd1, 1'b1);
    #1 chk("pair_ready", {31'd0, sb_ready}, 32'd1);
    tick();
    chk("pair_out_hold", {29'd0, outstanding}, 32'd2);
    chk("pair_busy", busy_vec, 32'h0000_000C);
    chk("pair_err0", {31'd0, sb_err}, 32'd0);
    present(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    retire(1'b1, 5'd7, 1'b1);
    tick();
    idle();
    chk("setwin_busy", busy_vec, 32'h0000_008C);
    chk("setwin_out", {29'd0, outstanding}, 32'd2);
    chk("setwin_err", {31'd0, sb_err}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_out", {29'd0, outstanding}, 32'd0);
    chk("arst_err", {31'd0, sb_err}, 32'd0);
    tick();
    rst = 1'b1;

    // Underflow retire and release of non-busy rd=9
    retire(1'b1, 5'd0, 1'b0);
    tick();
    retire(1'b0, 5'd0, 1'b0);
    chk("uflow_out", {29'd0, outstanding}, 32'd0);
    chk("uflow_err", {31'd0, sb_err}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("err_after_flush", {31'd0, sb_err}, 32'd1);
    do_reset();
    chk("err_cleared", {31'd0, sb_err}, 32'd0);
    present(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    retire(1'b1, 5'd9, 1'b1);
    tick();
    retire(1'b0, 5'd0, 1'b0);
    chk("nb9_err", {31'd0, sb_err}, 32'd1);
    chk("nb9_busy", busy_vec, 32'h0000_0002);
    chk("nb9_out", {29'd0, outstanding}, 32'd0);
    do_reset();

    // Fence with two in flight
    present(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    present(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    present(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("fence_stall", {31'd0, sb_ready}, 32'd0);
    retire(1'b1, 5'd1, 1'b1);
    tick();
    chk("fence_out1", {29'd0, outstanding}, 32'd1);
    chk("fence_nodone1", {31'd0, fence_done}, 32'd0);
    retire(1'b1, 5'd2, 1'b1);
    tick();
    retire(1'b0, 5'd0, 1'b0);
    chk("fence_out0", {29'd0, outstanding}, 32'd0);
    chk("fence_nodone2", {31'd0, fence_done}, 32'd0);
    #1 chk("fence_still_drain", {31'd0, sb_ready}, 32'd0);
    tick();
    chk("fence_done_pulse", {31'd0, fence_done}, 32'd1);
    chk("fence_run_ready", {31'd0, sb_ready}, 32'd1);
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    chk("fence_done_end", {31'd0, fence_done}, 32'd0);
    chk("fence_no_issue", busy_vec, 32'h0);

    // Fence with nothing in flight
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    chk("fence0_entry", {31'd0, fence_done}, 32'd0);
    #1 chk("fence0_drain", {31'd0, sb_ready}, 32'd0);
    tick();
    chk("fence0_pulse", {31'd0, fence_done}, 32'd1);
    tick();
    chk("fence0_end", {31'd0, fence_done}, 32'd0);

    // Flush during drain aborts it
    present(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fflush_out", {29'd0, outstanding}, 32'd0);
    chk("fflush_busy", busy_vec, 32'h0);
    chk("fflush_nodone", {31'd0, fence_done}, 32'd0);
    #1 chk("fflush_run", {31'd0, sb_ready}, 32'd1);
    tick();
    chk("fflush_no_late", {31'd0, fence_done}, 32'd0);

    // Reset during drain aborts it
    present(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rdrain_nodone", {31'd0, fence_done}, 32'd0);
    chk("rdrain_ready", {31'd0, sb_ready}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("rdrain_no_late", {31'd0, fence_done}, 32'd0);

    // x0 never tracked; rs2 and WAW hazards
    present(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
    #1 chk("x0_ready", {31'd0, sb_ready}, 32'd1);
    tick();
    chk("x0_busy", busy_vec, 32'h0);
    chk("x0_out", {29'd0, outstanding}, 32'd1);
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    retire(1'b1, 5'd0, 1'b1);
    tick();
    retire(1'b0, 5'd0, 1'b0);
    chk("x0_rel_out", {29'd0, outstanding}, 32'd0);
    chk("x0_rel_err", {31'd0, sb_err}, 32'd0);
    present(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    present(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1);
    #1 chk("rs2_hazard", {31'd0, sb_ready}, 32'd0);
    present(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 chk("waw_hazard", {31'd0, sb_ready}, 32'd0);
    present(1'b1, 5'd8, 1'b0, 5'd4, 1'b1, 5'd3, 1'b0);
    #1 chk("no_hazard_unused", {31'd0, sb_ready}, 32'd1);
    present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    retire(1'b1, 5'd3, 1'b1);
    tick();
    idle();
    chk("final_busy", busy_vec, 32'h0);
    chk("final_out", {29'd0, outstanding}, 32'd0);
    chk("final_err", {31'd0, sb_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
